interrupt_controller_n: RTL

//  N-channel prioritised, nestable interrupt controller for the ForthCPU core;

---
 rtl/interrupt_controller_n.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller_n.sv
// interrupt_controller_n: N-channel prioritised, nestable interrupt
// controller with per-channel masks, global enable and NMI bypass.
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_int[NUM_INT]        raw async requests (index 0 = highest priority)
//   i_int_ack             core vectoring pulse (honoured only while o_int_req)
//   i_reti                core executed RETI
//   i_ei / i_di           set / clear global enable
//   i_mask_wr, i_mask_din load channel enable mask
//   o_int_req             registered request to core
//   o_int_vector, o_int_id vector and channel index of current winner
//   o_ien                 global enable state
//   o_pending             pending request bits
//   o_in_service          nesting record
module interrupt_controller_n #(
  parameter int                 NUM_INT     = 8,
  parameter logic [15:0]        VEC_BASE    = 16'h0000,
  parameter int                 VEC_STRIDE  = 4,
  parameter logic [NUM_INT-1:0] EDGE_MASK   = {{(NUM_INT-1){1'b0}}, 1'b1},
  parameter logic [NUM_INT-1:0] NMI_MASK    = {{(NUM_INT-1){1'b0}}, 1'b1},
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_INT-1:0] i_int,
  input  logic               i_int_ack,
  input  logic               i_reti,
  input  logic               i_ei,
  input  logic               i_di,
  input  logic               i_mask_wr,
  input  logic [NUM_INT-1:0] i_mask_din,
  output logic               o_int_req,
  output logic [15:0]        o_int_vector,
  output logic [3:0]         o_int_id,
  output logic               o_ien,
  output logic [NUM_INT-1:0] o_pending,
  output logic [NUM_INT-1:0] o_in_service
);

  localparam logic [NUM_INT-1:0] ONE = {{(NUM_INT-1){1'b0}}, 1'b1};

  logic [NUM_INT-1:0] r_sync [SYNC_STAGES];
  logic [NUM_INT-1:0] r_sync_d;
  logic [NUM_INT-1:0] r_pending;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] r_in_service;
  logic [NUM_INT-1:0] r_ien_save;
  logic               r_ien;
  logic               r_int_req;
  logic [15:0]        r_int_vector;
  logic [3:0]         r_int_id;

  logic [NUM_INT-1:0] w_synced;
  logic [NUM_INT-1:0] w_rise;
  logic [NUM_INT-1:0] w_elig;
  logic [NUM_INT-1:0] w_is_low;
  logic [NUM_INT-1:0] w_allow;
  logic [NUM_INT-1:0] w_cand;
  logic [NUM_INT-1:0] w_ack_oh;
  logic [NUM_INT-1:0] w_reti_oh;
  logic [NUM_INT-1:0] w_pend_nxt;
  logic               w_found;
  logic               w_ack;
  logic               w_reti_hit;
  logic               w_ien_rst;
  logic               w_ien_new;
  logic [3:0]         w_win;
  logic [15:0]        w_vec;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~r_sync_d;
  assign w_elig   = r_pending &
                    (NMI_MASK | (r_mask & {NUM_INT{r_ien}}));

  // Lowest set in-service bit is the level being serviced now;
  // only strictly higher-priority (lower index) channels may nest.
  assign w_is_low = r_in_service & (~r_in_service + ONE);
  assign w_allow  = (r_in_service == '0) ? '1 : (w_is_low - ONE);
  assign w_cand   = w_elig & w_allow;
  assign w_found  = |w_cand;

  always_comb begin
    w_win = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = 4'(i);
    end
  end

  // 16-bit arithmetic so the vector wraps naturally.
  assign w_vec = VEC_BASE +
                 (16'(w_win) + 16'd1) * 16'(VEC_STRIDE);

  assign w_ack      = i_int_ack & r_int_req;
  assign w_ack_oh   = w_ack ? (ONE << r_int_id) : '0;
  assign w_reti_hit = i_reti & (|r_in_service);
  assign w_reti_oh  = w_reti_hit ? w_is_low : '0;

  // Ordering within a cycle: RETI restores, then EI/DI apply,
  // then ACK saves that value and clears the enable.
  assign w_ien_rst = w_reti_hit ? |(r_ien_save & w_is_low) : r_ien;
  assign w_ien_new = i_di ? 1'b0 : (i_ei ? 1'b1 : w_ien_rst);

  // A fresh edge arriving in the ACK cycle wins over the clear.
  assign w_pend_nxt =
    (EDGE_MASK & ((r_pending & ~w_ack_oh) | w_rise)) |
    (~EDGE_MASK & w_synced);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= i_int;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_sync_d <= w_synced;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending    <= '0;
      r_mask       <= '0;
      r_in_service <= '0;
      r_ien_save   <= '0;
      r_ien        <= 1'b0;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_int_id     <= '0;
    end else begin
      r_pending    <= w_pend_nxt;
      r_in_service <= (r_in_service & ~w_reti_oh) | w_ack_oh;
      r_ien_save   <= (r_ien_save & ~w_ack_oh) |
                      (w_ack_oh & {NUM_INT{w_ien_new}});
      r_ien        <= w_ack ? 1'b0 : w_ien_new;
      if (i_mask_wr) r_mask <= i_mask_din;
      // Request drops for one cycle after ACK so the core
      // never vectors twice on the same request.
      r_int_req    <= w_found & ~w_ack;
      r_int_vector <= w_found ? w_vec : '0;
      r_int_id     <= w_found ? w_win : '0;
    end
  end

  assign o_int_req    = r_int_req;
  assign o_int_vector = r_int_vector;
  assign o_int_id     = r_int_id;
  assign o_ien        = r_ien;
  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule
